// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP32 divide datapath.
package fp_div_pkg;

    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int FP_BIAS = 127;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

endpackage

// File: rtl/fp_div_round.sv
// Round-to-nearest-even increment on a normalized mantissa, with carry-out.
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int MW = MANT_W
) (
    input  logic [MW-1:0] mant_i,
    input  logic          guard_i,
    input  logic          sticky_i,
    output logic [MW-1:0] mant_r_o,
    output logic          carry_o
);

    logic inc;

    // Exact ties (guard set, nothing below) round only when that makes the lsb even.
    assign inc = guard_i & (sticky_i | mant_i[0]);
    assign {carry_o, mant_r_o} = {1'b0, mant_i} + {{MW{1'b0}}, inc};

endmodule

// File: rtl/fp_div_norm_round.sv
// FP32 divide back end: normalize/special-resolve, then round/pack, with valid/ready.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_div_norm_round
    import fp_div_pkg::*;
#(
    parameter int MW   = MANT_W,
    parameter int EW   = EXP_W,
    parameter int BIAS = FP_BIAS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp_a,
    input  logic [EW-1:0] in_exp_b,
    input  logic [1:0]    in_cls_a,
    input  logic [1:0]    in_cls_b,
    input  logic [MW+1:0] in_quot,
    input  logic [MW:0]   in_rem,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_result,
    output logic [3:0]    out_flags
);

    localparam int XW = EW + 2;
    typedef logic signed [XW-1:0] exp_t;

    fp_cls_t   cls_a, cls_b;
    logic      adv;
    logic      guard_d, sticky_d, special_d;
    logic [MW-1:0] mant_d;
    exp_t      exp_d;
    logic [31:0] spec_res_d;
    fp_flags_t spec_flags_d;

    logic      s1_valid_q, s1_sign_q, s1_special_q;
    logic [MW-1:0] s1_mant_q;
    exp_t      s1_exp_q;
    logic [31:0] s1_spec_res_q;
    fp_flags_t s1_spec_flags_q;

    logic [MW-1:0] mant_r;
    logic      carry;
    exp_t      exp_r;
    logic [31:0] result_d;
    fp_flags_t flags_d;

    logic      out_valid_q;
    logic [31:0] out_result_q;
    fp_flags_t out_flags_q;

    assign cls_a    = fp_cls_t'(in_cls_a);
    assign cls_b    = fp_cls_t'(in_cls_b);
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mant_d   = in_quot[MW:1];
        guard_d  = in_quot[0];
        sticky_d = |in_rem;
        exp_d    = exp_t'({2'b00, in_exp_a}) - exp_t'({2'b00, in_exp_b}) + exp_t'(BIAS);
        if (in_quot[MW+1]) begin
            mant_d   = in_quot[MW+1:2];
            guard_d  = in_quot[1];
            sticky_d = in_quot[0] | (|in_rem);
        end else begin
            exp_d = exp_d - exp_t'(1);
        end
    end

    always_comb begin
        special_d    = 1'b1;
        spec_res_d   = 32'h0;
        spec_flags_d = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            spec_res_d           = QNAN;
            spec_flags_d.invalid = 1'b1;
        end else if (cls_b == CLS_ZERO) begin
            spec_res_d               = {in_sign, PINF[30:0]};
            spec_flags_d.div_by_zero = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_res_d = {in_sign, PINF[30:0]};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            spec_res_d = {in_sign, 31'h0};
        end else begin
            special_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s1_valid_q <= 1'b0;
        else if (adv) s1_valid_q <= in_valid;
    end

    // NOTE: datapath registers are not reset; the stage valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_sign_q       <= in_sign;
            s1_mant_q       <= mant_d;
            s1_exp_q        <= exp_d;
            s1_special_q    <= special_d;
            s1_spec_res_q   <= spec_res_d;
            s1_spec_flags_q <= spec_flags_d;
        end
    end

`ifdef FP_DIV_RNE_EN
    logic s1_guard_q, s1_sticky_q;

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_guard_q  <= guard_d;
            s1_sticky_q <= sticky_d;
        end
    end

    fp_div_round #(.MW(MW)) u_round (
        .mant_i   (s1_mant_q),
        .guard_i  (s1_guard_q),
        .sticky_i (s1_sticky_q),
        .mant_r_o (mant_r),
        .carry_o  (carry)
    );
`else
    logic unused_gs;
    assign unused_gs = guard_d ^ sticky_d;
    assign mant_r    = s1_mant_q;
    assign carry     = 1'b0;
`endif

    // The hidden bit is implied by the packed format.
    logic unused_hidden;
    assign unused_hidden = mant_r[MW-1];

    always_comb begin
        exp_r    = s1_exp_q + exp_t'({{(XW-1){1'b0}}, carry});
        result_d = {s1_sign_q, exp_r[EW-1:0], mant_r[MW-2:0]};
        flags_d  = '0;
        if (s1_special_q) begin
            result_d = s1_spec_res_q;
            flags_d  = s1_spec_flags_q;
        end else if (exp_r >= exp_t'((1 << EW) - 1)) begin
            result_d         = {s1_sign_q, PINF[30:0]};
            flags_d.overflow = 1'b1;
        end else if (exp_r <= exp_t'(0)) begin
            result_d          = {s1_sign_q, 31'h0};
            flags_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 32'h0;
            out_flags_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result_q <= result_d;
                out_flags_q  <= flags_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_div_norm_round.sv
// Directed bench for fp_div_norm_round; expected values are hand-computed FP32 encodings.
module tb_fp_div_norm_round;
    import fp_div_pkg::*;

`ifdef FP_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sign;
    logic [7:0]  in_exp_a, in_exp_b;
    logic [1:0]  in_cls_a, in_cls_b;
    logic [25:0] in_quot;
    logic [24:0] in_rem;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int passed = 0;
    int total  = 0;
    int tx, rx;
    logic [31:0] held;
    bit held_v;
    logic [31:0] bp_exp [4];

    always #5 clk = ~clk;

    fp_div_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_a   (in_exp_a),
        .in_exp_b   (in_exp_b),
        .in_cls_a   (in_cls_a),
        .in_cls_b   (in_cls_b),
        .in_quot    (in_quot),
        .in_rem     (in_rem),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                         input fp_cls_t ca, input fp_cls_t cb,
                         input logic [25:0] q, input logic [24:0] r);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp_a = ea;
        in_exp_b = eb;
        in_cls_a = ca;
        in_cls_b = cb;
        in_quot  = q;
        in_rem   = r;
    endtask

    // One transaction with no backpressure: accepted, silent for one cycle, valid on the second.
    task automatic do_op(input string tag, input logic s, input logic [7:0] ea, input logic [7:0] eb,
                         input fp_cls_t ca, input fp_cls_t cb,
                         input logic [25:0] q, input logic [24:0] r,
                         input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, ea, eb, ca, cb, q, r);
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'h1);
        chk({tag, ".result"}, out_result, er);
        chk({tag, ".flags"}, 32'(out_flags), 32'(ef));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        drive(1'b0, 8'd0, 8'd0, CLS_ZERO, CLS_ZERO, 26'h0, 25'h0);
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.valid", 32'(out_valid), 32'h0);
        chk("reset.result", out_result, 32'h0);
        chk("reset.flags", 32'(out_flags), 32'h0);
        chk("reset.in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;

        do_op("div3_2",   0, 128, 128, CLS_NORM, CLS_NORM, 26'h3000000, 25'h0, 32'h3FC00000, 4'b0000);
        do_op("div1_3",   0, 127, 128, CLS_NORM, CLS_NORM, 26'h1555555, 25'h1,
              RNE ? 32'h3EAAAAAB : 32'h3EAAAAAA, 4'b0000);
        do_op("tie_even", 0, 128, 128, CLS_NORM, CLS_NORM, 26'h3000002, 25'h0, 32'h3FC00000, 4'b0000);
        do_op("tie_odd",  0, 128, 128, CLS_NORM, CLS_NORM, 26'h3000006, 25'h0,
              RNE ? 32'h3FC00002 : 32'h3FC00001, 4'b0000);
        do_op("carry",    0, 128, 128, CLS_NORM, CLS_NORM, 26'h3FFFFFF, 25'h0,
              RNE ? 32'h40000000 : 32'h3FFFFFFF, 4'b0000);
        do_op("carry_ovf", 0, 254, 127, CLS_NORM, CLS_NORM, 26'h3FFFFFF, 25'h0,
              RNE ? 32'h7F800000 : 32'h7F7FFFFF, RNE ? 4'b0010 : 4'b0000);
        do_op("ovf",      0, 254, 1,   CLS_NORM, CLS_NORM, 26'h2000000, 25'h0, 32'h7F800000, 4'b0010);
        do_op("e254",     0, 254, 127, CLS_NORM, CLS_NORM, 26'h2000000, 25'h0, 32'h7F000000, 4'b0000);
        do_op("e255",     0, 254, 126, CLS_NORM, CLS_NORM, 26'h2000000, 25'h0, 32'h7F800000, 4'b0010);
        do_op("unf",      0, 1,   254, CLS_NORM, CLS_NORM, 26'h2000000, 25'h0, 32'h00000000, 4'b0001);
        do_op("e1",       0, 1,   127, CLS_NORM, CLS_NORM, 26'h2000000, 25'h0, 32'h00800000, 4'b0000);
        do_op("e0_neg",   1, 1,   127, CLS_NORM, CLS_NORM, 26'h1000000, 25'h0, 32'h80000000, 4'b0001);
        do_op("x_zero",   1, 128, 128, CLS_NORM, CLS_ZERO, 26'h2000000, 25'h0, 32'hFF800000, 4'b0100);
        do_op("zero_zero", 0, 128, 128, CLS_ZERO, CLS_ZERO, 26'h2000000, 25'h0, 32'h7FC00000, 4'b1000);
        do_op("norm_inf", 1, 128, 128, CLS_NORM, CLS_INF,  26'h2000000, 25'h0, 32'h80000000, 4'b0000);
        do_op("inf_norm", 1, 128, 128, CLS_INF,  CLS_NORM, 26'h2000000, 25'h0, 32'hFF800000, 4'b0000);
        do_op("nan",      1, 128, 128, CLS_NAN,  CLS_NORM, 26'h2000000, 25'h0, 32'h7FC00000, 4'b1000);
        do_op("inf_inf",  1, 128, 128, CLS_INF,  CLS_INF,  26'h2000000, 25'h0, 32'h7FC00000, 4'b1000);
        do_op("inf_zero", 0, 128, 128, CLS_INF,  CLS_ZERO, 26'h2000000, 25'h0, 32'h7F800000, 4'b0100);
        do_op("zero_norm", 0, 1,  254, CLS_ZERO, CLS_NORM, 26'h2000000, 25'h0, 32'h00000000, 4'b0000);

        // Four back-to-back inputs with the sink stalled for three cycles.
        bp_exp[0] = 32'h3FC00000;
        bp_exp[1] = 32'h40400000;
        bp_exp[2] = 32'h40C00000;
        bp_exp[3] = 32'h41400000;
        tx = 0;
        rx = 0;
        held_v = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            if (tx < 4) drive(1'b0, 8'(128 + tx), 8'd128, CLS_NORM, CLS_NORM, 26'h3000000, 25'h0);
            else in_valid = 1'b0;
            #1;
            if (out_valid) begin
                if (out_ready) begin
                    if (rx < 4) chk($sformatf("bp.out%0d", rx), out_result, bp_exp[rx]);
                    else chk("bp.dup", 32'(out_valid), 32'h0);
                    rx++;
                    held_v = 1'b0;
                end else begin
                    chk("bp.stall_in_ready", 32'(in_ready), 32'h0);
                    if (held_v) chk("bp.hold", out_result, held);
                    held   = out_result;
                    held_v = 1'b1;
                end
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp.sent", 32'(tx), 32'd4);
        chk("bp.received", 32'(rx), 32'd4);

        // Reset while a transaction sits in stage 1.
        @(negedge clk);
        drive(1'b0, 8'd128, 8'd128, CLS_NORM, CLS_NORM, 26'h3000000, 25'h0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.result", out_result, 32'h0);
        chk("rst.flags", 32'(out_flags), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.discard", 32'(out_valid), 32'h0);

        do_op("post_rst", 0, 128, 128, CLS_NORM, CLS_NORM, 26'h3000000, 25'h0, 32'h3FC00000, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_div_norm_round.md
Name: fp_div_norm_round

Overview:
Downstream stage of the FP32 divide datapath.
- Consumes the raw mantissa quotient and remainder from the mantissa divider, together with the operand exponents, sign and class.
- Produces the packed IEEE-754 single-precision result and exception flags.
- Two-stage pipeline (normalize, then round/pack) with valid/ready handshake on both sides.

Parameters:
MW, 24, mantissa width including hidden bit; quotient is MW+2 bits in Q1.(MW+1) format
EW, 8, exponent field width
BIAS, 127, exponent bias

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream data valid
in_ready  out  1  stage can accept
in_sign  in  1  sign_a XOR sign_b
in_exp_a  in  EW  biased exponent of dividend
in_exp_b  in  EW  biased exponent of divisor
in_cls_a  in  2  operand class: ZERO, NORM, INF, NAN
in_cls_b  in  2  divisor class
in_quot  in  MW+2  mantissa ratio Ma/Mb, Q1.(MW+1), range (0.5,2)
in_rem  in  MW+1  divider remainder; nonzero means inexact
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  32  packed FP32 result
out_flags  out  4  {invalid, div_by_zero, overflow, underflow}

Behaviour:
Clock, reset and global stall:
- One clock; reset is synchronous and active-high on rst.
- Reset clears both stage valids. out_valid=0, out_result=0, out_flags=0.
- Reset mid-operation discards in-flight data.
- adv = !out_valid || out_ready; in_ready = adv. When adv=0 the whole pipe stalls and holds out_result/out_flags stable.
- Latency is 2 cycles from an accepted input to out_valid with no backpressure. Throughput is 1/cycle.

Stage 1 (normalize), registered on adv:
- If quot[MW+1]=1: mant = quot[MW+1:2], guard = quot[1], sticky = quot[0] | (rem!=0), e = ea - eb + BIAS.
- Else: mant = quot[MW:1], guard = quot[0], sticky = (rem!=0), e = ea - eb + BIAS - 1.
- e is computed in EW+2 bits, signed.
- Special class is resolved here, in priority order:
  1. Any NaN, 0/0 or INF/INF: qNaN 0x7FC00000, invalid.
  2. b ZERO: signed INF, div_by_zero.
  3. a INF: signed INF, no flag.
  4. a ZERO or b INF: signed zero, no flag.

Stage 2 (round/pack):
- RNE: inc = guard & (sticky | mant[0]).
- mant+inc carries out to 1<<MW: mantissa field becomes 0 and e is incremented.
- Then e >= 2^EW-1: signed INF (0x7F800000|sign<<31), overflow.
- e <= 0: signed zero, underflow (flush-to-zero; no subnormal output).
- Otherwise pack {sign, e[EW-1:0], mant[MW-2:0]}.
- Special results bypass rounding.

Optional Feature:
FP_DIV_RNE_EN
- Defined: round-to-nearest-even as specified in Stage 2.
- Undefined: round toward zero (inc=0 always); the rounder sub-module is not instantiated; guard/sticky are not registered.
- Flags and specials are identical in both builds.

Decomposition:
Package fp_div_pkg:
- FP_BIAS, EXP_W, MANT_W
- fp_cls_t enum {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN}
- fp_flags_t packed struct
- QNAN/PINF constants
Sub-module fp_div_round:
- Combinational RNE increment and carry-out.
- Inputs: mant, guard, sticky. Outputs: mant_r, carry.

Test Plan:
3.0/2.0: ea=eb=128, quot=0x3000000, rem=0 -> 0x3FC00000, flags 0, out_valid 2 cycles after accept.
1.0/3.0: ea=127, eb=128, quot=0x1555555, rem≠0 -> 0x3EAAAAAB (RNE); 0x3EAAAAAA without FP_DIV_RNE_EN.
Tie and carry:
- guard=1, sticky=0, mant lsb=0 -> no increment.
- mant=0xFFFFFF, guard=1, sticky=1 -> mantissa field 0, exponent+1.
Overflow/underflow:
- ea=254, eb=1, quot=0x2000000 -> 0x7F800000, overflow.
- ea=1, eb=254 -> 0x00000000, underflow.
Specials:
- NORM/ZERO, sign=1 -> 0xFF800000, div_by_zero.
- ZERO/ZERO -> 0x7FC00000, invalid.
- NORM/INF -> signed zero.
Backpressure and reset:
- 4 back-to-back inputs with out_ready low for 3 cycles -> in_ready=0 while stalled, out_result held stable, no loss or duplication, order preserved.
- rst asserted mid-stream -> out_valid=0 the following cycle.
